// File: rtl/prom_read_arbiter_if.sv
// Requester and PROM port-A signal bundle for prom_read_arbiter.
// slave = arbiter side, master = requester/PROM side.
interface prom_read_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 36
);
   logic                  Req0;
   logic                  Req1;
   logic [ADDR_WIDTH-1:0] Addr0;
   logic [ADDR_WIDTH-1:0] Addr1;
   logic [7:0]            Len0;
   logic [7:0]            Len1;
   logic                  Gnt0;
   logic                  Gnt1;
   logic                  RdValid0;
   logic                  RdValid1;
   logic [DATA_WIDTH-1:0] RdData;
   logic                  Done0;
   logic                  Done1;
   logic                  PromClkEn;
   logic                  PromWeRen;
   logic [ADDR_WIDTH-1:0] PromAddress;
   logic [DATA_WIDTH-1:0] PromDataOut;

   modport slave (
      input  Req0, Req1, Addr0, Addr1, Len0, Len1, PromDataOut,
      output Gnt0, Gnt1, RdValid0, RdValid1, RdData, Done0, Done1,
             PromClkEn, PromWeRen, PromAddress
   );

   modport master (
      output Req0, Req1, Addr0, Addr1, Len0, Len1, PromDataOut,
      input  Gnt0, Gnt1, RdValid0, RdValid1, RdData, Done0, Done1,
             PromClkEn, PromWeRen, PromAddress
   );
endinterface

// File: rtl/prom_read_arbiter.sv
// Round-robin burst arbiter sharing the PROM read port between two requesters.
// Define PROM_ARB_OUTREG_EN to add one output register stage on RdData/RdValid/Done.
module prom_read_arbiter #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 36
) (
   input  logic                 Clk0,
   input  logic                 AsyncReset0,
   input  logic                 ClkEn0,
   prom_read_arbiter_if.slave   bus
);

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e                state_q;
   logic                  ptr_q;
   logic                  owner_q;
   logic [ADDR_WIDTH-1:0] cursor_q;
   logic [7:0]            remaining_q;
   logic                  gnt0_q;
   logic                  gnt1_q;

   logic                  p_vld_q;
   logic                  p_tag_q;
   logic                  p_last_q;

   logic                  rd_valid0_q;
   logic                  rd_valid1_q;
   logic                  done0_q;
   logic                  done1_q;
   logic [DATA_WIDTH-1:0] rd_data_q;

   logic                  winner;
   logic                  any_req;
   logic                  src_vld;
   logic                  src_tag;
   logic                  src_last;
   logic [DATA_WIDTH-1:0] src_data;

   assign any_req = bus.Req0 | bus.Req1;
   // Pointed-to requester wins if requesting, otherwise the other one.
   assign winner  = ptr_q ? bus.Req1 : ~bus.Req0;

   // Arbitration and burst sequencing; Req is only looked at in IDLE.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge Clk0 or posedge AsyncReset0) begin
      if (AsyncReset0) begin
         state_q     <= IDLE;
         ptr_q       <= 1'b0;
         owner_q     <= 1'b0;
         cursor_q    <= '0;
         remaining_q <= '0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
      end else if (ClkEn0) begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  owner_q     <= winner;
                  ptr_q       <= ~winner;
                  cursor_q    <= winner ? bus.Addr1 : bus.Addr0;
                  remaining_q <= winner ? bus.Len1 : bus.Len0;
                  gnt0_q      <= ~winner;
                  gnt1_q      <= winner;
                  state_q     <= BURST;
               end
            end
            BURST: begin
               cursor_q <= cursor_q + ADDR_WIDTH'(1);
               if (remaining_q == 8'd0) begin
                  state_q <= IDLE;
                  gnt0_q  <= 1'b0;
                  gnt1_q  <= 1'b0;
               end else begin
                  remaining_q <= remaining_q - 8'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Tracks each issue so its data returns to the right requester.
   always_ff @(posedge Clk0 or posedge AsyncReset0) begin
      if (AsyncReset0) begin
         p_vld_q  <= 1'b0;
         p_tag_q  <= 1'b0;
         p_last_q <= 1'b0;
      end else if (ClkEn0) begin
         p_vld_q  <= (state_q == BURST);
         p_tag_q  <= owner_q;
         p_last_q <= (remaining_q == 8'd0);
      end
   end

`ifdef PROM_ARB_OUTREG_EN
   logic                  s_vld_q;
   logic                  s_tag_q;
   logic                  s_last_q;
   logic [DATA_WIDTH-1:0] s_data_q;

   always_ff @(posedge Clk0 or posedge AsyncReset0) begin
      if (AsyncReset0) begin
         s_vld_q  <= 1'b0;
         s_tag_q  <= 1'b0;
         s_last_q <= 1'b0;
         s_data_q <= '0;
      end else if (ClkEn0) begin
         s_vld_q  <= p_vld_q;
         s_tag_q  <= p_tag_q;
         s_last_q <= p_last_q;
         if (p_vld_q) begin
            s_data_q <= bus.PromDataOut;
         end
      end
   end

   assign src_vld  = s_vld_q;
   assign src_tag  = s_tag_q;
   assign src_last = s_last_q;
   assign src_data = s_data_q;
`else
   assign src_vld  = p_vld_q;
   assign src_tag  = p_tag_q;
   assign src_last = p_last_q;
   assign src_data = bus.PromDataOut;
`endif

   // Valid/Done clear while stalled so a pulse never stretches; the upstream
   // stage holds its entry, so nothing is lost or repeated on resume.
   always_ff @(posedge Clk0 or posedge AsyncReset0) begin
      if (AsyncReset0) begin
         rd_valid0_q <= 1'b0;
         rd_valid1_q <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         rd_valid0_q <= ClkEn0 & src_vld & ~src_tag;
         rd_valid1_q <= ClkEn0 & src_vld &  src_tag;
         done0_q     <= ClkEn0 & src_vld & src_last & ~src_tag;
         done1_q     <= ClkEn0 & src_vld & src_last &  src_tag;
         if (ClkEn0 && src_vld) begin
            rd_data_q <= src_data;
         end
      end
   end

   assign bus.Gnt0        = gnt0_q;
   assign bus.Gnt1        = gnt1_q;
   assign bus.RdValid0    = rd_valid0_q;
   assign bus.RdValid1    = rd_valid1_q;
   assign bus.Done0       = done0_q;
   assign bus.Done1       = done1_q;
   assign bus.RdData      = rd_data_q;
   assign bus.PromClkEn   = ClkEn0 & (state_q == BURST);
   assign bus.PromWeRen   = 1'b0;
   assign bus.PromAddress = cursor_q;

endmodule

// File: tb/tb_prom_read_arbiter.sv
// Directed bench for prom_read_arbiter with a behavioural PROM and event logs.
// Honours PROM_ARB_OUTREG_EN for the expected read latency.
module tb_prom_read_arbiter;

`ifdef PROM_ARB_OUTREG_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   typedef struct {
      int         cyc;
      logic [7:0] addr;
   } iss_t;

   typedef struct {
      int          cyc;
      logic        tag;
      logic [35:0] data;
      logic        done;
   } val_t;

   logic Clk0;
   logic rst;
   logic clken;

   prom_read_arbiter_if #(.ADDR_WIDTH(8), .DATA_WIDTH(36)) bus ();

   prom_read_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(36)) dut (
      .Clk0        (Clk0),
      .AsyncReset0 (rst),
      .ClkEn0      (clken),
      .bus         (bus.slave)
   );

   int   cyc = 0;
   int   n_assert = 0;
   int   n_fail = 0;
   int   overlap = 0;
   int   stray = 0;
   int   gnt0_cyc = 0;
   iss_t iss_q[$];
   val_t val_q[$];

   function automatic logic [35:0] prom_word(input logic [7:0] a);
      return {4'hC, a ^ 8'h5A, a, ~a, a + 8'd1};
   endfunction

   initial begin
      Clk0 = 1'b0;
      forever #5 Clk0 = ~Clk0;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   always @(posedge Clk0) cyc++;

   always @(posedge Clk0) begin
      if (bus.PromClkEn) bus.PromDataOut <= prom_word(bus.PromAddress);
   end

   always @(negedge Clk0) begin
      if (bus.PromClkEn) iss_q.push_back('{cyc, bus.PromAddress});
      if (bus.RdValid0) val_q.push_back('{cyc, 1'b0, bus.RdData, bus.Done0});
      if (bus.RdValid1) val_q.push_back('{cyc, 1'b1, bus.RdData, bus.Done1});
      if (bus.RdValid0 && bus.RdValid1) overlap++;
      if ((bus.Done0 && !bus.RdValid0) || (bus.Done1 && !bus.RdValid1)) stray++;
      if (bus.Gnt0) gnt0_cyc++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      iss_q.delete();
      val_q.delete();
      gnt0_cyc = 0;
   endtask

   // Steps cycles, dropping each Req on its Gnt, until both bursts are granted and
   // finished, then lets the read pipeline drain.
   task automatic serve(input string tag, input int budget);
      int k = 0;
      while ((bus.Req0 || bus.Req1 || bus.Gnt0 || bus.Gnt1) && k < budget) begin
         @(posedge Clk0);
         #1;
         k++;
         if (bus.Gnt0) bus.Req0 = 1'b0;
         if (bus.Gnt1) bus.Req1 = 1'b0;
      end
      check({tag, "_within_budget"}, 64'(k < budget), 64'd1);
      repeat (LAT + 2) @(posedge Clk0);
      #1;
   endtask

   task automatic check_burst(input string tag, input logic owner, input logic [7:0] start,
                              input int n, input int first_cyc, input int ib, input int vb,
                              input bit timed);
      for (int i = 0; i < n; i++) begin
         logic [7:0] a;
         a = start + 8'(i);
         if (ib + i < iss_q.size()) begin
            check({tag, "_iss_addr"}, 64'(iss_q[ib+i].addr), 64'(a));
            if (timed) check({tag, "_iss_cyc"}, 64'(iss_q[ib+i].cyc), 64'(first_cyc + i));
         end
         if (vb + i < val_q.size()) begin
            check({tag, "_val_tag"}, 64'(val_q[vb+i].tag), 64'(owner));
            check({tag, "_val_data"}, 64'(val_q[vb+i].data), 64'(prom_word(a)));
            check({tag, "_val_done"}, 64'(val_q[vb+i].done), 64'(i == n - 1));
            if (timed) check({tag, "_val_cyc"}, 64'(val_q[vb+i].cyc), 64'(first_cyc + i + LAT));
         end
      end
   endtask

   initial begin
      int e;
      int s;
      int cnt;

      rst = 1'b1;
      clken = 1'b1;
      bus.Req0 = 1'b0;
      bus.Req1 = 1'b0;
      bus.Addr0 = 8'h00;
      bus.Addr1 = 8'h00;
      bus.Len0 = 8'h00;
      bus.Len1 = 8'h00;
      #1;
      check("rst_gnt", 64'({bus.Gnt1, bus.Gnt0}), 64'd0);
      check("rst_valid", 64'({bus.RdValid1, bus.RdValid0}), 64'd0);
      check("rst_done", 64'({bus.Done1, bus.Done0}), 64'd0);
      check("rst_prom_ctl", 64'({bus.PromClkEn, bus.PromWeRen}), 64'd0);
      check("rst_prom_addr", 64'(bus.PromAddress), 64'd0);
      check("rst_rddata", 64'(bus.RdData), 64'd0);
      repeat (2) @(posedge Clk0);
      #1;
      rst = 1'b0;

      // Single-word burst: latency and one-cycle grant.
      clear_logs();
      bus.Addr0 = 8'h10;
      bus.Len0 = 8'd0;
      bus.Req0 = 1'b1;
      e = cyc + 1;
      serve("t1", 20);
      check("t1_n_iss", 64'(iss_q.size()), 64'd1);
      check("t1_n_val", 64'(val_q.size()), 64'd1);
      check_burst("t1", 1'b0, 8'h10, 1, e, 0, 0, 1'b1);
      check("t1_gnt0_cycles", 64'(gnt0_cyc), 64'd1);

      // Address wrap-around for requester 1.
      clear_logs();
      bus.Addr1 = 8'hFE;
      bus.Len1 = 8'd3;
      bus.Req1 = 1'b1;
      e = cyc + 1;
      serve("t2", 30);
      check("t2_n_iss", 64'(iss_q.size()), 64'd4);
      check("t2_n_val", 64'(val_q.size()), 64'd4);
      check_burst("t2", 1'b1, 8'hFE, 4, e, 0, 0, 1'b1);

      // Simultaneous requests, twice: requester 0 first each time, 1-cycle bubble.
      for (int r = 0; r < 2; r++) begin
         clear_logs();
         bus.Addr0 = 8'h30;
         bus.Len0 = 8'd1;
         bus.Addr1 = 8'h38;
         bus.Len1 = 8'd1;
         bus.Req0 = 1'b1;
         bus.Req1 = 1'b1;
         e = cyc + 1;
         serve("t3", 40);
         check("t3_n_iss", 64'(iss_q.size()), 64'd4);
         check("t3_n_val", 64'(val_q.size()), 64'd4);
         check_burst("t3_req0", 1'b0, 8'h30, 2, e, 0, 0, 1'b1);
         check_burst("t3_req1", 1'b1, 8'h38, 2, e + 3, 2, 2, 1'b1);
      end

      // Three-cycle ClkEn0 stall mid-burst.
      clear_logs();
      bus.Addr0 = 8'h20;
      bus.Len0 = 8'd7;
      bus.Req0 = 1'b1;
      @(posedge Clk0);
      #1;
      check("t4_gnt0", 64'(bus.Gnt0), 64'd1);
      bus.Req0 = 1'b0;
      repeat (3) @(posedge Clk0);
      #1;
      clken = 1'b0;
      s = cyc;
      repeat (3) @(posedge Clk0);
      #1;
      clken = 1'b1;
      serve("t4", 40);
      check("t4_n_iss", 64'(iss_q.size()), 64'd8);
      check("t4_n_val", 64'(val_q.size()), 64'd8);
      check_burst("t4", 1'b0, 8'h20, 8, 0, 0, 0, 1'b0);
      cnt = 0;
      foreach (val_q[i]) if (val_q[i].cyc >= s + 1 && val_q[i].cyc <= s + 3) cnt++;
      check("t4_no_valid_in_stall", 64'(cnt), 64'd0);
      cnt = 0;
      foreach (iss_q[i]) if (iss_q[i].cyc >= s && iss_q[i].cyc <= s + 2) cnt++;
      check("t4_no_issue_in_stall", 64'(cnt), 64'd0);

      // Asynchronous reset during a burst.
      clear_logs();
      bus.Addr0 = 8'h40;
      bus.Len0 = 8'd15;
      bus.Req0 = 1'b1;
      @(posedge Clk0);
      #1;
      bus.Req0 = 1'b0;
      repeat (3) @(posedge Clk0);
      #1;
      rst = 1'b1;
      #1;
      check("t5_gnt", 64'({bus.Gnt1, bus.Gnt0}), 64'd0);
      check("t5_valid", 64'({bus.RdValid1, bus.RdValid0}), 64'd0);
      check("t5_done", 64'({bus.Done1, bus.Done0}), 64'd0);
      check("t5_prom", 64'({bus.PromClkEn, bus.PromAddress}), 64'd0);
      check("t5_rddata", 64'(bus.RdData), 64'd0);
      @(posedge Clk0);
      #1;
      rst = 1'b0;
      repeat (3) @(posedge Clk0);
      #1;
      cnt = 0;
      foreach (val_q[i]) if (val_q[i].done) cnt++;
      check("t5_no_done", 64'(cnt), 64'd0);
      check("t5_aborted", 64'(iss_q.size() < 16), 64'd1);

      clear_logs();
      bus.Addr0 = 8'h50;
      bus.Len0 = 8'd0;
      bus.Addr1 = 8'h60;
      bus.Len1 = 8'd0;
      bus.Req0 = 1'b1;
      bus.Req1 = 1'b1;
      e = cyc + 1;
      serve("t5b", 30);
      check("t5b_n_val", 64'(val_q.size()), 64'd2);
      check_burst("t5b_req0", 1'b0, 8'h50, 1, e, 0, 0, 1'b1);
      check_burst("t5b_req1", 1'b1, 8'h60, 1, e + 2, 1, 1, 1'b1);

      // Maximum-length burst over the whole address space.
      clear_logs();
      bus.Addr0 = 8'h00;
      bus.Len0 = 8'd255;
      bus.Req0 = 1'b1;
      e = cyc + 1;
      serve("t6", 400);
      check("t6_n_iss", 64'(iss_q.size()), 64'd256);
      check("t6_n_val", 64'(val_q.size()), 64'd256);
      check("t6_gnt0_cycles", 64'(gnt0_cyc), 64'd256);
      check_burst("t6", 1'b0, 8'h00, 256, e, 0, 0, 1'b1);

      check("no_valid_overlap", 64'(overlap), 64'd0);
      check("no_stray_done", 64'(stray), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/prom_read_arbiter.md
Name: prom_read_arbiter

Overview:
- Shares the single read port (port A) of the 36-bit alta_ram4k PROM between two requesters.
- Round-robin arbitration at burst granularity. A granted requester gets a burst of consecutive reads with address wrap-around.
- Read data returns tagged to the owning requester, with one-cycle valid pulses and an end-of-burst pulse.

Parameters:
- ADDR_WIDTH, 8, PROM word address width; bursts wrap modulo 2^ADDR_WIDTH.
- DATA_WIDTH, 36, PROM data width.

Ports:
- Clk0  in  1  single clock, rising edge.
- AsyncReset0  in  1  asynchronous, active-high reset.
- ClkEn0  in  1  global enable; low freezes all state.
- Req0, Req1  in  1 each  burst request; level, held until matching Gnt.
- Addr0, Addr1  in  ADDR_WIDTH each  burst start address; stable while Req high.
- Len0, Len1  in  8 each  burst length minus one (0 gives 1 word, 255 gives 256 words).
- Gnt0, Gnt1  out  1 each  high for the whole granted burst.
- RdValid0, RdValid1  out  1 each  one-cycle data-valid pulse.
- RdData  out  DATA_WIDTH  shared read data, qualified by RdValid0/1.
- Done0, Done1  out  1 each  pulses together with the last RdValid of a burst.
- PromClkEn  out  1  to PROM ClkEn0.
- PromWeRen  out  1  to PROM WeRenA; constant 0 (read).
- PromAddress  out  ADDR_WIDTH  to PROM AddressA.
- PromDataOut  in  DATA_WIDTH  from PROM DataOutA; valid 1 cycle after an enabled issue.

Behaviour:
- Reset (async, immediate): state IDLE; all outputs 0; cursor, remaining count and tags 0; priority pointer favours requester 0.
- ClkEn0 low: no register updates, PromClkEn=0, no new valids. Resumes exactly where it stopped, with no skipped or duplicated address.
- States: IDLE, BURST.
- IDLE, at a clock edge with ClkEn0=1 and any Req high:
  - Winner is the requester pointed to if it is requesting, else the other requester.
  - Latch cursor=Addr_w and remaining=Len_w; assert Gnt_w; go to BURST.
  - Pointer moves to the non-winner.
- Req is sampled only in IDLE. A requester deasserts Req on seeing Gnt. Req falling mid-burst is ignored; the burst always completes.
- BURST, each enabled cycle:
  - PromClkEn=1, PromAddress=cursor.
  - cursor = cursor+1 mod 2^ADDR_WIDTH.
  - remaining decrements.
  - If remaining==0 this cycle, it is the last issue: next state IDLE and Gnt drops at that edge.
- Data path:
  - A tag/valid/last pipeline register tracks each issue.
  - On the edge after an issue: RdValid_tag=1 and RdData=PromDataOut for one cycle.
  - Done_tag=1 on the last issue's data.
  - RdValid/Done are 0 in all other cycles. RdData holds its last value when not valid.
- Latency:
  - Req sampled at edge E gives Gnt high after E.
  - First PROM issue happens in the cycle after E.
  - First RdValid comes 2 edges after E.
  - A burst of N words takes N consecutive issue cycles. A new grant is possible in the IDLE cycle immediately following, so there is a 1-cycle bubble between bursts.
- Simultaneous requests: strict alternation while both stay asserted.
- Reset mid-burst: burst aborted, in-flight data discarded, no Done emitted.

Optional Feature:
- PROM_ARB_OUTREG_EN defined:
  - Adds one output register stage on RdData/RdValid/Done, for use with PROM PORTA_OUTREG="yes" timing closure.
  - Read latency becomes issue + 2 edges.
  - Stage freezes with ClkEn0 and is cleared by reset.
  - Grant/issue timing is unchanged.
- Undefined: latency as stated in Behaviour.

Test Plan:
- After reset: Req0, Addr0=0x10, Len0=0 → PromAddress=0x10 for one cycle. RdValid0 and Done0 pulse together 2 edges after the Req sample, carrying RdData=PROM[0x10]. Gnt0 high for exactly 1 cycle.
- Req1, Addr1=0xFE, Len1=3 → PROM addresses FE, FF, 00, 01 in order. 4 RdValid1 pulses; Done1 only on the 4th.
- Req0 and Req1 asserted in the same cycle after reset, each Len=1 → requester 0 bursts first. Requester 1 is granted in the IDLE cycle after, with no valids overlapping between the two. A repeat of both requests serves requester 0 first again.
- ClkEn0 low for 3 cycles mid-burst (Addr0=0x20, Len0=7) → no valids during the stall. Exactly 8 valids for 0x20..0x27 with no gaps or duplicates in address.
- AsyncReset0 pulse during a burst → all outputs 0 immediately without waiting for a clock. No Done. The next request is served normally with requester 0 priority.
- Len0=255, Addr0=0 → 256 consecutive valids 0x00..0xFF; Done0 on the 256th. With PROM_ARB_OUTREG_EN, the same test shows every valid shifted one cycle later.
